// File: rtl/mem_responder.sv
// Word-addressed synchronous memory answering MAR/MDR requests after a fixed latency.
// Optional out-of-range detection on the upper address bits: define ADDR_RANGE_CHECK_EN.
module mem_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] mar_addr,
  input  logic [31:0] mdr_data,
  input  logic        read,
  input  logic        write,
  output logic [31:0] mdatain,
  output logic        mem_ready,
  output logic        busy,
  output logic        addr_err
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        op_rd_q, op_rd_d;
  logic [31:0] mdatain_q, mdatain_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [31:0]           mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  oor;
  logic                  commit;
  logic                  mem_we;

  assign idx = addr_q[ADDR_WIDTH-1:0];

`ifdef ADDR_RANGE_CHECK_EN
  assign oor = |addr_q[31:ADDR_WIDTH];
`else
  // Upper bits ignored: addresses alias modulo depth.
  logic addr_hi_unused;
  assign addr_hi_unused = |addr_q[31:ADDR_WIDTH];
  assign oor = 1'b0;
`endif

  assign commit = (state_q == WAIT) && (cnt_q == 4'd1);
  assign mem_we = commit && !op_rd_q && !oor;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_rd_d   = op_rd_q;
    mdatain_d = mdatain_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          addr_d  = mar_addr;
          wdata_d = mdr_data;
          op_rd_d = read;
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (commit) begin
          if (op_rd_q) begin
            mdatain_d = oor ? 32'h0 : mem[idx];
          end
          ready_d = 1'b1;
          err_d   = oor;
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      mdatain_q <= 32'h0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mdatain_q <= mdatain_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    op_rd_q <= op_rd_d;
  end

  // Reset on the commit edge wins, so the array write is gated by clr too.
  always_ff @(posedge clk) begin
    if (clr && mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign mdatain   = mdatain_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign addr_err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard of expected completions, checked on mem_ready.
module tb_mem_responder;

  localparam int AW  = 9;
  localparam int LAT = 2;

  logic        clk;
  logic        clr;
  logic [31:0] mar_addr;
  logic [31:0] mdr_data;
  logic        read;
  logic        write;
  logic [31:0] mdatain;
  logic        mem_ready;
  logic        busy;
  logic        addr_err;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .clr       (clr),
    .mar_addr  (mar_addr),
    .mdr_data  (mdr_data),
    .read      (read),
    .write     (write),
    .mdatain   (mdatain),
    .mem_ready (mem_ready),
    .busy      (busy),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access; exp_md is the required mdatain when mem_ready is high.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_md,
                        input logic exp_err, input logic hold, input string tag);
    exp_t e;
    int   n;
    @(negedge clk);
    read = rd; write = wr; mar_addr = addr; mdr_data = data;
    e.data = exp_md; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    chk({tag, "_busy_e0"}, {31'b0, busy}, 32'd1);
    chk({tag, "_rdy_e0"}, {31'b0, mem_ready}, 32'd0);
    @(negedge clk);
    mar_addr = ~addr; mdr_data = ~data;
    if (!hold) begin read = 1'b0; write = 1'b0; end
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (mem_ready) break;
    end
    chk({tag, "_latency"}, n, LAT);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_mdatain"}, mdatain, e.data);
      chk({tag, "_addr_err"}, {31'b0, addr_err}, {31'b0, e.err});
    end
    @(posedge clk); #1;
    chk({tag, "_rdy_fall"}, {31'b0, mem_ready}, 32'd0);
    chk({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
    chk({tag, "_md_hold"}, mdatain, e.data);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic seen;
    clr = 1'b0; read = 1'b0; write = 1'b0; mar_addr = '0; mdr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mdatain", mdatain, 32'h0);
    chk("rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, addr_err}, 32'd0);
    @(negedge clk); clr = 1'b1;

    access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "wr5");
    access(1'b1, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd5");
    access(1'b0, 1'b1, 32'd6, 32'h1, 32'hDEADBEEF, 1'b0, 1'b0, "wr6");
    access(1'b1, 1'b0, 32'd6, 32'h0, 32'h1, 1'b0, 1'b1, "rd6_hold");
    access(1'b1, 1'b1, 32'd5, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0, "rdwr5");
    access(1'b1, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd5b");
    access(1'b0, 1'b1, 32'd7, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "wr7_pre");

    // Reset one edge after acceptance aborts the write.
    @(negedge clk);
    write = 1'b1; mar_addr = 32'd7; mdr_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("abort_busy_e0", {31'b0, busy}, 32'd1);
    @(negedge clk); write = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", {31'b0, mem_ready}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_mdatain", mdatain, 32'h0);
    @(negedge clk); clr = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ready || busy) seen = 1'b1;
    end
    chk("abort_quiet", {31'b0, seen}, 32'd0);
    access(1'b1, 1'b0, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0, "rd7");

    // Reset on the commit edge suppresses the write.
    access(1'b0, 1'b1, 32'd8, 32'h11111111, 32'h0, 1'b0, 1'b0, "wr8");
    @(negedge clk);
    write = 1'b1; mar_addr = 32'd8; mdr_data = 32'h22222222;
    @(posedge clk);
    @(negedge clk); write = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk); clr = 1'b0;
    @(posedge clk); #1;
    chk("commit_rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("commit_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); clr = 1'b1;
    access(1'b1, 1'b0, 32'd8, 32'h0, 32'h11111111, 1'b0, 1'b0, "rd8");

`ifdef ADDR_RANGE_CHECK_EN
    access(1'b0, 1'b1, 32'h205, 32'hAAAA5555, 32'h11111111, 1'b1, 1'b0, "wr205");
    access(1'b1, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd5_noalias");
    access(1'b1, 1'b0, 32'h205, 32'h0, 32'h0, 1'b1, 1'b0, "rd205");
`else
    access(1'b0, 1'b1, 32'h205, 32'hAAAA5555, 32'h11111111, 1'b0, 1'b0, "wr205");
    access(1'b1, 1'b0, 32'd5, 32'h0, 32'hAAAA5555, 1'b0, 1'b0, "rd5_alias");
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed synchronous memory that answers the datapath's MAR/MDR memory requests. It sits on the far side of the MDR. It samples the MAR address, the MDR write data and the read/write strobes, waits a fixed access latency, then performs the access. Read data is returned on the Mdatain input of the MDR mux, and a one-cycle ready pulse tells the control unit that the access is complete.

## Interface
- ADDR_WIDTH, 9, number of word-address bits; depth = 2**ADDR_WIDTH 32-bit words
- LATENCY, 2, cycles from request acceptance to completion; legal range 1..15
- clk  input  1  clock; all state updates on its rising edge
- clr  input  1  reset; synchronous, active-low
- mar_addr  input  32  word address from MAR; bits [ADDR_WIDTH-1:0] index the array
- mdr_data  input  32  write data from MDR output
- read  input  1  read request; level-sampled in IDLE
- write  input  1  write request; level-sampled in IDLE
- mdatain  output  32  read data to the MDR mux Mdatain leg
- mem_ready  output  1  access-complete pulse, exactly one cycle
- busy  output  1  high whenever state is not IDLE
- addr_err  output  1  out-of-range access flag; see Configuration

## Operation
- Reset (clr=0 at an edge) sets state=IDLE, cnt=0, mdatain=32'h0, mem_ready=0, busy=0, addr_err=0. The array contents are NOT cleared.
- The FSM has three states: IDLE, WAIT and DONE.
- IDLE, with read|write high at an edge:
  - latch mar_addr, mdr_data and op into internal registers;
  - if read=1, op=READ; else op=WRITE (read wins when both are high);
  - load cnt=LATENCY and go to WAIT.
- WAIT, when cnt==1 at an edge:
  - perform the access using the latched address and data;
  - on READ, load mdatain from the array;
  - on WRITE, store the latched data into the array;
  - set mem_ready=1 and go to DONE.
- WAIT, otherwise: cnt decrements.
- DONE, at the next edge: mem_ready=0 and go to IDLE. Requests are ignored in DONE.
- Changes to mar_addr, mdr_data, read or write after acceptance have no effect on the access in flight.
- Requests are level-sensitive. The initiator must drop read/write once mem_ready is seen; a strobe still high in IDLE starts a new access.
- mdatain holds the last read value until the next read completes. Writes never change mdatain.
- A read of a never-written location returns X in simulation; tests must write a location before reading it.

## Timing
- Request accepted at edge E0. Access and mem_ready rise at edge E0+LATENCY. mem_ready falls and the FSM returns to IDLE at E0+LATENCY+1. The earliest next acceptance is E0+LATENCY+2.
- Throughput: one access per LATENCY+2 cycles.
- busy goes high at E0 and low at E0+LATENCY+1.
- mdatain is valid in the same cycle that mem_ready is high, and stays stable afterwards.
- Reset mid-operation (in WAIT, before the commit edge) aborts the access: no array write, no mem_ready pulse, mdatain=0.
- Reset on the commit edge takes priority: the access is not performed.
- cnt is 4 bits wide. LATENCY=1 gives WAIT for exactly one cycle.

## Configuration
- ADDR_RANGE_CHECK_EN, defined: an access whose latched mar_addr[31:ADDR_WIDTH] is nonzero is out of range.
  - An out-of-range write is suppressed.
  - An out-of-range read returns 32'h0 on mdatain.
  - addr_err pulses high together with mem_ready; mem_ready still pulses.
- ADDR_RANGE_CHECK_EN, undefined: upper address bits are ignored, so addresses alias modulo depth. addr_err is tied to 0.

## Test plan
- LATENCY=2: write=1, mar_addr=5, mdr_data=32'hDEADBEEF accepted at E0 -> busy=1 at E0; mem_ready=1 only in cycle E0+2; busy=0 after E0+3.
- Read mar_addr=5 after the write above -> mdatain=32'hDEADBEEF while mem_ready=1; value holds after a subsequent write of 32'h1 to address 6.
- read=1 and write=1 together, mar_addr=5, mdr_data=32'h12345678 -> behaves as a read returning 32'hDEADBEEF; a later read of address 5 still returns 32'hDEADBEEF.
- Write 32'hCAFEF00D to address 7, with clr=0 one edge after acceptance -> no mem_ready pulse; mdatain=0; FSM in IDLE. A later read of address 7 does not return 32'hCAFEF00D (the location was pre-written 32'h0).
- With ADDR_RANGE_CHECK_EN: write 32'hAAAA5555 to address 32'h205 -> addr_err=1 and mem_ready=1 in the same cycle; a read of address 5 still returns 32'hDEADBEEF; a read of address 32'h205 returns 0 with addr_err=1.
- Without ADDR_RANGE_CHECK_EN: write 32'hAAAA5555 to address 32'h205, then read address 5 -> 32'hAAAA5555, addr_err=0.
